crypto_bus_arbiter: RTL and testbench
=====================================

Name: crypto_bus_arbiter

Overview:
- Two-master round-robin arbiter in front of the single crypto peripheral MMIO slave port (AES, Ed25519/SHAKE, BIKE, RSA and RAM windows at 0x4000_0000..0x4000_4FFF).
- Master 0 is the CPU core; master 1 is the DMA engine.
- Serialises accesses and enforces a one-cycle bus recovery gap between transactions.
- Returns an error response on address-decode miss or slave timeout, so neither master can hang the bus.

Parameters:
- BASE_ADDR, 32'h4000_0000, first byte of the crypto window.
- SPAN, 32'h0000_5000, window size in bytes; decode hit is BASE_ADDR <= addr < BASE_ADDR+SPAN.
- TIMEOUT, 16, maximum cycles s_valid stays high without s_ready (minimum 2).
- ERR_DATA, 32'hDEAD_BEEF, rdata returned on any error response.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- m0_addr / m1_addr  in  32  master byte address
- m0_wdata / m1_wdata  in  32  write data
- m0_wstrb / m1_wstrb  in  4  byte strobes
- m0_we / m1_we  in  1  1 = write
- m0_valid / m1_valid  in  1  request, held until m*_ready
- m0_rdata / m1_rdata  out  32  read data
- m0_ready / m1_ready  out  1  one-cycle completion pulse
- s_addr, s_wdata, s_wstrb, s_we  out  32/32/4/1  forwarded request fields
- s_valid  out  1  request to slave
- s_rdata  in  32  slave read data
- s_ready  in  1  slave completion
- err_clr  in  1  clears sticky error flags
- err_decode  out  1  sticky: decode miss occurred
- err_timeout  out  1  sticky: slave timeout occurred
- busy  out  1  state != IDLE
- grant  out  1  index of master currently or last granted

Behaviour:
- Reset:
  - All outputs 0.
  - State IDLE, timeout counter 0.
  - Internal last_grant = 1, so master 0 wins the first contention.
- FSM states: IDLE, ACCESS, ERR, RECOVER.
- IDLE:
  - Sample m0_valid and m1_valid.
  - One request: grant that master.
  - Both requesting: grant !last_grant.
  - Update last_grant and grant on grant.
  - Granted address hits the window: go to ACCESS.
  - Granted address misses: go to ERR.
- ACCESS:
  - s_* mirror the granted master's fields combinationally; s_valid = 1.
  - Counter increments each cycle.
  - On s_ready: granted m*_ready = 1 and m*_rdata = s_rdata in the same cycle (combinational), then go to RECOVER.
  - If no s_ready and counter == TIMEOUT-1: m*_ready = 1, m*_rdata = ERR_DATA, err_timeout set, go to RECOVER.
  - s_ready in the same cycle as the timeout counts as a normal completion and wins.
- ERR:
  - s_valid = 0.
  - m*_ready = 1 with m*_rdata = ERR_DATA; err_decode set.
  - Go to RECOVER.
- RECOVER:
  - s_valid = 0 for exactly one cycle; counter cleared; go to IDLE.
  - This gap lets the registered-ready slaves drop ready and lets the master deassert valid.
- Latency:
  - Minimum 3 cycles per transaction: IDLE grant, ACCESS with 1-cycle slave, RECOVER.
  - Back-to-back throughput is one access per 3 cycles for 1-cycle slaves.
- Non-granted master: m*_ready = 0 and m*_rdata = 0 at all times.
- Granted master's rdata outside its ready cycle is 0.
- Writes: m*_rdata = 0 on the ready cycle (s_rdata ignored when we = 1).
- Master contract:
  - The master holds addr/wdata/wstrb/we stable while valid is high.
  - Dropping valid before ready is a protocol violation; the arbiter still completes the transaction and the ready pulse is discarded.
- Sticky errors:
  - Cleared by err_clr.
  - If err_clr and a new error occur in the same cycle, the set wins.
- Reset asserted mid-ACCESS: s_valid drops in the next cycle, no ready pulse is issued, state returns to IDLE.
- Address arithmetic: decode uses 33-bit compare, so BASE_ADDR+SPAN may equal 2^32 without wrap error.

Decomposition:
- Package crypto_bus_pkg holds:
  - state enum {IDLE, ACCESS, ERR, RECOVER};
  - CRYPTO_BASE and CRYPTO_SPAN constants;
  - ERR_DATA constant;
  - per-peripheral base constants (AES 0x4000_0000, ED 0x4000_1000, BIKE 0x4000_2000, RSA 0x4000_3000, RAM 0x4000_4000).
- One sub-module, rr_arbiter2: two request inputs, last_grant register, grant output and update enable.
- The FSM, mux and timeout counter live in the top module.

Test Plan:
- m0 write 0x4000_4004 = 0x1234_5678, slave ready 1 cycle later -> s_valid high 1 cycle with forwarded fields; m0_ready pulses in that cycle; s_valid low in RECOVER; busy returns low on cycle 3.
- m0 and m1 both valid continuously with reads to 0x4000_4000 -> grants alternate 0,1,0,1; m0 served first after reset; each master gets exactly one ready per grant.
- m1 read of 0x5000_0000 -> no s_valid ever; m1_ready the cycle after grant with rdata 0xDEAD_BEEF; err_decode = 1 until err_clr.
- m0 read with slave never asserting ready, TIMEOUT = 16 -> s_valid high exactly 16 cycles; m0_ready with 0xDEAD_BEEF; err_timeout = 1; next request is granted normally.
- s_ready arrives on the 16th ACCESS cycle with s_rdata = 0xCAFE_0001 -> m0_rdata = 0xCAFE_0001; err_timeout stays 0.
- rst asserted on the 2nd ACCESS cycle -> all outputs 0 the next cycle; no ready pulse; first grant after reset goes to m0 under contention.

Source files
------------

// File: rtl/crypto_bus_pkg.sv
// Shared definitions for the crypto peripheral bus arbiter: FSM states,
// address map of the crypto MMIO window and the window decode helper.
package crypto_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        ERR     = 2'd2,
        RECOVER = 2'd3
    } state_t;

    localparam logic [31:0] CRYPTO_BASE     = 32'h4000_0000;
    localparam logic [31:0] CRYPTO_SPAN     = 32'h0000_5000;
    localparam logic [31:0] CRYPTO_ERR_DATA = 32'hDEAD_BEEF;

    localparam logic [31:0] AES_BASE  = 32'h4000_0000;
    localparam logic [31:0] ED_BASE   = 32'h4000_1000;
    localparam logic [31:0] BIKE_BASE = 32'h4000_2000;
    localparam logic [31:0] RSA_BASE  = 32'h4000_3000;
    localparam logic [31:0] RAM_BASE  = 32'h4000_4000;

    // 33-bit compare so a window ending exactly at 2^32 does not wrap.
    function automatic logic addr_hit(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] span);
        logic [32:0] a;
        logic [32:0] lo;
        logic [32:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + {1'b0, span};
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/crypto_bus_arbiter_rr.sv
// Two-requester round-robin picker; remembers the last winner so the other
// requester wins the next contention.
module rr_arbiter2 (
    input  logic clk,
    input  logic rst,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_en,
    output logic o_valid,
    output logic o_idx
);

    logic r_last;

    assign o_valid = i_req0 | i_req1;
    assign o_idx   = (i_req0 & i_req1) ? ~r_last : i_req1;

    // Reset to 1 so master 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (i_en && o_valid) begin
            r_last <= o_idx;
        end
    end

endmodule

// File: rtl/crypto_bus_arbiter.sv
// Round-robin arbiter between CPU (master 0) and DMA (master 1) in front of the
// crypto MMIO slave, with decode-miss/timeout error responses and a recovery gap.
module crypto_bus_arbiter
    import crypto_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = CRYPTO_BASE,
    parameter logic [31:0] SPAN      = CRYPTO_SPAN,
    parameter int unsigned TIMEOUT   = 16,
    parameter logic [31:0] ERR_DATA  = CRYPTO_ERR_DATA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    input  logic        m0_we,
    input  logic        m0_valid,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    input  logic        m1_we,
    input  logic        m1_valid,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    output logic        s_we,
    output logic        s_valid,
    input  logic [31:0] s_rdata,
    input  logic        s_ready,
    input  logic        err_clr,
    output logic        err_decode,
    output logic        err_timeout,
    output logic        busy,
    output logic        grant
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_grant;
    logic          r_err_decode;
    logic          r_err_timeout;

    logic          w_arb_en;
    logic          w_arb_valid;
    logic          w_arb_idx;
    logic [31:0]   w_arb_addr;
    logic [31:0]   w_sel_addr;
    logic [31:0]   w_sel_wdata;
    logic [3:0]    w_sel_wstrb;
    logic          w_sel_we;
    logic          w_in_access;
    logic          w_done_ok;
    logic          w_timeout;
    logic          w_resp;
    logic [31:0]   w_resp_data;

    assign w_arb_en = (r_state == IDLE);

    rr_arbiter2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .i_req0  (m0_valid),
        .i_req1  (m1_valid),
        .i_en    (w_arb_en),
        .o_valid (w_arb_valid),
        .o_idx   (w_arb_idx)
    );

    assign w_arb_addr  = w_arb_idx ? m1_addr  : m0_addr;
    assign w_sel_addr  = r_grant   ? m1_addr  : m0_addr;
    assign w_sel_wdata = r_grant   ? m1_wdata : m0_wdata;
    assign w_sel_wstrb = r_grant   ? m1_wstrb : m0_wstrb;
    assign w_sel_we    = r_grant   ? m1_we    : m0_we;

    // A slave ready on the last allowed cycle is a normal completion.
    assign w_in_access = (r_state == ACCESS);
    assign w_done_ok   = w_in_access & s_ready;
    assign w_timeout   = w_in_access & ~s_ready & (r_cnt == CNT_LAST);

    // No completion is reported while reset is being applied.
    assign w_resp      = (w_done_ok | w_timeout | (r_state == ERR)) & ~rst;
    assign w_resp_data = w_done_ok ? (w_sel_we ? 32'h0 : s_rdata) : ERR_DATA;

    assign m0_ready = w_resp & ~r_grant;
    assign m1_ready = w_resp &  r_grant;
    assign m0_rdata = m0_ready ? w_resp_data : 32'h0;
    assign m1_rdata = m1_ready ? w_resp_data : 32'h0;

    assign s_valid  = w_in_access;
    assign s_addr   = w_in_access ? w_sel_addr  : 32'h0;
    assign s_wdata  = w_in_access ? w_sel_wdata : 32'h0;
    assign s_wstrb  = w_in_access ? w_sel_wstrb : 4'h0;
    assign s_we     = w_in_access & w_sel_we;

    assign err_decode  = r_err_decode;
    assign err_timeout = r_err_timeout;
    assign busy        = (r_state != IDLE);
    assign grant       = r_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_grant       <= 1'b0;
            r_err_decode  <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            // A new error in the same cycle as err_clr keeps the flag set.
            r_err_decode  <= (r_err_decode  & ~err_clr) | (r_state == ERR);
            r_err_timeout <= (r_err_timeout & ~err_clr) | w_timeout;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_arb_valid) begin
                        r_grant <= w_arb_idx;
                        r_state <= addr_hit(w_arb_addr, BASE_ADDR, SPAN) ? ACCESS : ERR;
                    end
                end
                ACCESS: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_done_ok || w_timeout) begin
                        r_state <= RECOVER;
                    end
                end
                ERR: begin
                    r_state <= RECOVER;
                end
                RECOVER: begin
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crypto_bus_arbiter.sv
// Randomised scoreboard bench for crypto_bus_arbiter: two behavioural masters,
// an address-programmed slave, a reference model and a decoupled monitor.
`timescale 1ns/1ps
module tb_crypto_bus_arbiter;

    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
    localparam int          TMO  = 16;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        we;
        int          gap;
    } req_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        we;
        logic [31:0] rdata;
        int          cyc;
        bit          dec;
        bit          to;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_wstrb [2];
    logic [1:0]  m_we;
    logic [1:0]  m_valid;
    logic [31:0] m_rdata [2];
    logic [1:0]  m_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        s_we, s_valid, s_ready;
    logic        err_clr, err_decode, err_timeout, busy, grant;

    int   checks = 0;
    int   errors = 0;
    bit   abort  = 0;
    logic [1:0] m_busy;
    req_t req_q0[$], req_q1[$];
    exp_t exp_q0[$], exp_q1[$];
    int   ord_q[$];

    crypto_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_addr(m_addr[0]), .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]), .m0_we(m_we[0]),
        .m0_valid(m_valid[0]), .m0_rdata(m_rdata[0]), .m0_ready(m_ready[0]),
        .m1_addr(m_addr[1]), .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]), .m1_we(m_we[1]),
        .m1_valid(m_valid[1]), .m1_rdata(m_rdata[1]), .m1_ready(m_ready[1]),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_we(s_we), .s_valid(s_valid),
        .s_rdata(s_rdata), .s_ready(s_ready),
        .err_clr(err_clr), .err_decode(err_decode), .err_timeout(err_timeout),
        .busy(busy), .grant(grant)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "simulation did not finish");
    end

    // Slave answers on the Nth s_valid cycle, N taken from addr[6:2] (0 means 1).
    function automatic int lat_of(input logic [31:0] a);
        int l;
        l = int'(a[6:2]);
        return (l == 0) ? 1 : l;
    endfunction

    function automatic logic [31:0] slave_data(input logic [31:0] a);
        return a ^ 32'hCAFE_0001;
    endfunction

    function automatic exp_t model(input req_t r);
        exp_t   e;
        longint a;
        int     lat;
        a   = r.addr;
        lat = lat_of(r.addr);
        e.addr = r.addr; e.wdata = r.wdata; e.wstrb = r.wstrb; e.we = r.we;
        e.dec = 0; e.to = 0;
        if (a < 64'h4000_0000 || a >= 64'h4000_5000) begin
            e.rdata = ERRD; e.cyc = 0; e.dec = 1;
        end else if (lat > TMO) begin
            e.rdata = ERRD; e.cyc = TMO; e.to = 1;
        end else begin
            e.rdata = r.we ? 32'h0 : slave_data(r.addr);
            e.cyc   = lat;
        end
        return e;
    endfunction

    function automatic logic any_out();
        return |{m_ready, m_rdata[0], m_rdata[1], s_addr, s_wdata, s_wstrb, s_we, s_valid,
                 err_decode, err_timeout, busy, grant};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic issue(input int k, input logic [31:0] addr, input logic we,
                         input logic [31:0] wdata, input logic [3:0] wstrb, input int gap);
        req_t r;
        r.addr = addr; r.we = we; r.wdata = wdata; r.wstrb = wstrb; r.gap = gap;
        if (k == 0) req_q0.push_back(r); else req_q1.push_back(r);
    endtask

    task automatic issue_rand(input int k);
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0:       a = 32'h5000_0000 | ($urandom & 32'h0FFF_FFFC);
            1:       a = 32'h4000_5000 + ($urandom_range(0, 255) << 2);
            2:       a = 32'h3FFF_FFFC;
            default: a = 32'h4000_0000 + (32'($urandom_range(0, 32'h4FFF)) & 32'hFFFF_FFFC);
        endcase
        issue(k, a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 3));
    endtask

    task automatic run_master(input int k);
        req_t r;
        exp_t e;
        int   wt;
        m_valid[k] = 0; m_we[k] = 0; m_addr[k] = 0; m_wdata[k] = 0; m_wstrb[k] = 0;
        m_busy[k] = 0;
        forever begin
            @(posedge clk); #1;
            if (abort || rst || (k == 0 ? req_q0.size() == 0 : req_q1.size() == 0)) begin
                m_valid[k] = 0;
                continue;
            end
            if (k == 0) r = req_q0.pop_front(); else r = req_q1.pop_front();
            m_busy[k] = 1;
            for (int g = 0; g < r.gap; g++) begin
                m_valid[k] = 0;
                @(posedge clk); #1;
            end
            m_addr[k] = r.addr; m_wdata[k] = r.wdata; m_wstrb[k] = r.wstrb; m_we[k] = r.we;
            m_valid[k] = 1;
            e = model(r);
            if (k == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
            wt = 0;
            while (1) begin
                @(negedge clk); #3;
                if (abort || m_ready[k]) break;
                wt++;
                if (wt > 300) begin
                    checks++; errors++;
                    $display("FAIL m%0d_ready_wait act=%0d_cycles exp=below_300", k, wt);
                    break;
                end
            end
            m_busy[k] = 0;
        end
    endtask

    initial run_master(0);
    initial run_master(1);

    // Slave model plus response monitor.
    initial begin : monitor
        int          scnt, s_cycles;
        logic [31:0] cap_addr, cap_wdata;
        logic [3:0]  cap_wstrb;
        logic        cap_we, prev_resp, exp_dec, exp_to, set_dec, set_to;
        exp_t        e;
        s_ready = 0; s_rdata = 0; scnt = 0; s_cycles = 0; prev_resp = 0;
        exp_dec = 0; exp_to = 0;
        cap_addr = 0; cap_wdata = 0; cap_wstrb = 0; cap_we = 0;
        forever begin
            @(negedge clk);
            if (s_valid) begin
                scnt++;
                s_ready = (scnt == lat_of(s_addr));
                s_rdata = s_ready ? slave_data(s_addr) : $urandom;
            end else begin
                scnt = 0; s_ready = 0; s_rdata = $urandom;
            end
            #2;
            chk("err_decode", 32'(err_decode), 32'(exp_dec));
            chk("err_timeout", 32'(err_timeout), 32'(exp_to));
            chk("single_ready", 32'(m_ready == 2'b11), 32'h0);
            for (int k = 0; k < 2; k++)
                if (!m_ready[k]) chk($sformatf("m%0d_idle_rdata", k), m_rdata[k], 32'h0);
            set_dec = 0; set_to = 0;
            if (rst) begin
                chk("no_ready_in_reset", 32'(m_ready), 32'h0);
                exp_dec = 0; exp_to = 0; s_cycles = 0; prev_resp = 0;
            end else begin
                if (prev_resp) begin
                    chk("recover_s_valid", 32'(s_valid), 32'h0);
                    chk("recover_busy", 32'(busy), 32'h1);
                end
                if (s_valid) begin
                    if (s_cycles == 0) begin
                        cap_addr = s_addr; cap_wdata = s_wdata; cap_wstrb = s_wstrb; cap_we = s_we;
                    end
                    s_cycles++;
                end
                for (int k = 0; k < 2; k++) begin
                    if (m_ready[k]) begin
                        if (k == 0 ? exp_q0.size() == 0 : exp_q1.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL m%0d_unexpected_ready act=1 exp=0", k);
                        end else begin
                            if (k == 0) e = exp_q0.pop_front(); else e = exp_q1.pop_front();
                            $display("txn m%0d addr=%h we=%0d rdata=%h s_cycles=%0d",
                                     k, e.addr, e.we, m_rdata[k], s_cycles);
                            chk($sformatf("m%0d_rdata", k), m_rdata[k], e.rdata);
                            chk($sformatf("m%0d_s_cycles", k), 32'(s_cycles), 32'(e.cyc));
                            chk("grant_idx", 32'(grant), 32'(k));
                            chk("busy_on_ready", 32'(busy), 32'h1);
                            if (e.cyc > 0) begin
                                chk("fwd_addr", cap_addr, e.addr);
                                chk("fwd_we", 32'(cap_we), 32'(e.we));
                                chk("fwd_wdata", cap_wdata, e.wdata);
                                chk("fwd_wstrb", 32'(cap_wstrb), 32'(e.wstrb));
                            end
                            if (ord_q.size() > 0) chk("rr_order", 32'(k), 32'(ord_q.pop_front()));
                            set_dec = e.dec; set_to = e.to;
                        end
                        s_cycles = 0;
                    end
                end
                prev_resp = |m_ready;
                exp_dec = (exp_dec & ~err_clr) | set_dec;
                exp_to  = (exp_to  & ~err_clr) | set_to;
            end
        end
    end

    task automatic drain(input bit rnd_clr);
        int n;
        n = 0;
        while ((req_q0.size() != 0 || req_q1.size() != 0 || exp_q0.size() != 0 ||
                exp_q1.size() != 0 || m_busy != 2'b00) && n < 4000) begin
            @(posedge clk); #1;
            if (rnd_clr) err_clr = ($urandom_range(0, 5) == 0);
            n++;
        end
        checks++;
        if (n >= 4000) begin
            errors++;
            $display("FAIL drain act=%0d_cycles exp=below_4000", n);
        end
        repeat (3) @(posedge clk);
        #1;
        if (rnd_clr) err_clr = 0;
    endtask

    task automatic contention(input int n);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            issue(0, 32'h4000_4000, 1'b0, 32'h0, 4'h0, 0);
            issue(1, 32'h4000_4000, 1'b0, 32'h0, 4'h0, 0);
            ord_q.push_back(0);
            ord_q.push_back(1);
        end
        drain(0);
        chk("rr_order_drained", 32'(ord_q.size()), 32'h0);
    endtask

    initial begin : main
        int wt;
        rst = 1; err_clr = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); #3;
        chk("reset_outputs_zero", 32'(any_out()), 32'h0);
        @(posedge clk); #1;
        rst = 0;

        contention(6);

        @(negedge clk);
        issue(0, 32'h4000_4004, 1'b1, 32'h1234_5678, 4'hF, 0);
        drain(0);

        @(negedge clk);
        issue(1, 32'h5000_0000, 1'b0, 32'h0, 4'h0, 0);
        drain(0);
        chk("err_decode_sticky", 32'(err_decode), 32'h1);
        err_clr = 1;
        @(posedge clk); #1;
        err_clr = 0;
        @(negedge clk); #3;
        chk("err_decode_cleared", 32'(err_decode), 32'h0);

        err_clr = 1;
        @(negedge clk);
        issue(1, 32'h4000_5000, 1'b0, 32'h0, 4'h0, 0);
        issue(0, 32'h4000_4FFC, 1'b0, 32'h0, 4'h0, 0);
        issue(1, 32'h3FFF_FFFC, 1'b1, 32'h5555_AAAA, 4'h3, 1);
        drain(0);
        err_clr = 0;

        @(negedge clk);
        issue(0, 32'h4000_3044, 1'b0, 32'h0, 4'h0, 0);
        issue(0, 32'h4000_3040, 1'b0, 32'h0, 4'h0, 0);
        issue(0, 32'h4000_1004, 1'b1, 32'hA5A5_0F0F, 4'h9, 0);
        drain(0);
        chk("err_timeout_sticky", 32'(err_timeout), 32'h1);

        @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            issue_rand(0);
            issue_rand(1);
        end
        drain(1);

        // Reset lands on the second ACCESS cycle, the same cycle the slave answers.
        @(negedge clk);
        issue(0, 32'h4000_0008, 1'b0, 32'h0, 4'h0, 0);
        wt = 0;
        while (wt < 50) begin
            @(negedge clk); #3;
            if (s_valid) break;
            wt++;
        end
        chk("mid_reset_access_seen", 32'(s_valid), 32'h1);
        @(posedge clk); #1;
        rst = 1; abort = 1;
        exp_q0.delete();
        @(posedge clk); #1;
        @(negedge clk); #3;
        chk("mid_reset_outputs_zero", 32'(any_out()), 32'h0);
        @(posedge clk); #1;
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        abort = 0;

        contention(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
